// File: rtl/spi_port_arbiter_if.sv
// spi_port_arbiter_if: core byte port, CRAS word port and spi_controller signals of spi_port_arbiter.
// slave = arbiter view; master = environment (requesters plus controller) view.
interface spi_port_arbiter_if;
    logic        c_lock, c_wr, c_rd, c_ignore, c_busy, c_data_avail;
    logic [7:0]  c_din, c_dout;
    logic        r_wr, r_rd, r_rdy;
    logic [31:0] r_addr, r_din, r_dout;
    logic        spi_wr, spi_rd, spi_ignore_response;
    logic        spi_data_avail, spi_buffer_empty, spi_buffer_full;
    logic [7:0]  spi_din, spi_dout;

    modport slave (
        input  c_lock, c_wr, c_rd, c_ignore, c_din,
        output c_busy, c_data_avail, c_dout,
        input  r_wr, r_rd, r_addr, r_din,
        output r_rdy, r_dout,
        output spi_wr, spi_rd, spi_ignore_response, spi_din,
        input  spi_data_avail, spi_buffer_empty, spi_buffer_full, spi_dout
    );

    modport master (
        output c_lock, c_wr, c_rd, c_ignore, c_din,
        input  c_busy, c_data_avail, c_dout,
        output r_wr, r_rd, r_addr, r_din,
        input  r_rdy, r_dout,
        input  spi_wr, spi_rd, spi_ignore_response, spi_din,
        output spi_data_avail, spi_buffer_empty, spi_buffer_full, spi_dout
    );
endinterface

// File: rtl/spi_port_arbiter.sv
// spi_port_arbiter: shares one byte-wide spi_controller between the core MMIO byte port and CRAS word frames.
// Define SPI_ARB_RR_EN to break IDLE ties round-robin; otherwise CRAS always wins ties.
module spi_port_arbiter #(
    parameter logic [7:0] CMD_WRITE = 8'h02,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] DUMMY     = 8'h00
) (
    input logic clk,
    input logic rst_n,
    spi_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CORE, RAS_TX, RAS_RX, RAS_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic        tx_done_q, tx_done_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] rx_sh_q, rx_sh_d;
    logic [31:0] r_dout_q, r_dout_d;
    logic        last_ras_q, last_ras_d;
    logic        ras_req, core_first, push, pop;
    logic [63:0] frame;
    logic        unused_addr_hi;

    assign ras_req = bus.r_wr | bus.r_rd;
`ifdef SPI_ARB_RR_EN
    assign core_first = bus.c_lock & (~ras_req | last_ras_q);
`else
    assign core_first = bus.c_lock & ~ras_req;
`endif
    assign frame          = {op_wr_q ? CMD_WRITE : CMD_READ, addr_q, op_wr_q ? din_q : {4{DUMMY}}};
    assign push           = (state_q == RAS_TX) & ~tx_done_q & ~bus.spi_buffer_full;
    // Read responses can land while the frame is still being pushed, so capture in TX and RX alike.
    assign pop            = (state_q == RAS_TX || state_q == RAS_RX) & ~op_wr_q & bus.spi_data_avail & ~rx_cnt_q[2];
    assign bus.c_dout       = bus.spi_dout;
    assign bus.c_data_avail = bus.spi_data_avail & (state_q == CORE);
    assign bus.r_dout       = r_dout_q;
    assign unused_addr_hi   = ^bus.r_addr[31:24];

    always_comb begin
        state_d    = state_q;
        tx_idx_d   = tx_idx_q;
        tx_done_d  = tx_done_q;
        rx_cnt_d   = pop ? rx_cnt_q + 3'd1 : rx_cnt_q;
        rx_sh_d    = pop ? {rx_sh_q[23:0], bus.spi_dout} : rx_sh_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        din_d      = din_q;
        r_dout_d   = r_dout_q;
        last_ras_d = last_ras_q;
        bus.c_busy              = 1'b1;
        bus.r_rdy               = 1'b0;
        bus.spi_wr              = 1'b0;
        bus.spi_rd              = pop;
        bus.spi_din             = 8'h00;
        bus.spi_ignore_response = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_first) begin
                    state_d    = CORE;
                    last_ras_d = 1'b0;
                end else if (ras_req) begin
                    state_d   = RAS_TX;
                    op_wr_d   = bus.r_wr;
                    addr_d    = bus.r_addr[23:0];
                    din_d     = bus.r_din;
                    tx_idx_d  = 3'd0;
                    tx_done_d = 1'b0;
                    rx_cnt_d  = 3'd0;
                end
            end
            CORE: begin
                bus.c_busy              = 1'b0;
                bus.spi_wr              = bus.c_wr;
                bus.spi_rd              = bus.c_rd;
                bus.spi_din             = bus.c_din;
                bus.spi_ignore_response = bus.c_ignore;
                if (!bus.c_lock && bus.spi_buffer_empty && !bus.spi_data_avail) state_d = IDLE;
            end
            RAS_TX: begin
                bus.spi_wr              = push;
                bus.spi_din             = frame[{~tx_idx_q, 3'b000} +: 8];
                bus.spi_ignore_response = op_wr_q | ~tx_idx_q[2];
                if (push) tx_idx_d = tx_idx_q + 3'd1;
                if (push && tx_idx_q == 3'd7) begin
                    tx_done_d = op_wr_q;
                    state_d   = op_wr_q ? RAS_TX : RAS_RX;
                end
                // Writes complete only once the controller has drained the whole frame.
                if (tx_done_q && bus.spi_buffer_empty) state_d = RAS_DONE;
            end
            RAS_RX: begin
                if (rx_cnt_d == 3'd4) begin
                    state_d  = RAS_DONE;
                    r_dout_d = rx_sh_d;
                end
            end
            RAS_DONE: begin
                bus.r_rdy  = 1'b1;
                last_ras_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_idx_q   <= 3'd0;
            tx_done_q  <= 1'b0;
            rx_cnt_q   <= 3'd0;
            rx_sh_q    <= 32'h0;
            op_wr_q    <= 1'b0;
            addr_q     <= 24'h0;
            din_q      <= 32'h0;
            r_dout_q   <= 32'h0;
            last_ras_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_idx_q   <= tx_idx_d;
            tx_done_q  <= tx_done_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            r_dout_q   <= r_dout_d;
            last_ras_q <= last_ras_d;
        end
    end
endmodule

// File: tb/tb_spi_port_arbiter.sv
// tb_spi_port_arbiter: random core/CRAS traffic against a behavioural spi_controller and frame-level reference.
// Honours SPI_ARB_RR_EN for the tie-break expectations.
module tb_spi_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [8:0]  txq[$];
    logic [8:0]  pushed[$];
    logic [7:0]  rxq[$];
    logic [7:0]  resp[$];
    logic [7:0]  resp_fixed[$];
    int shift_t = 0;
    int rdy_cnt = 0;
    int stall_viol = 0;
    bit force_full = 1'b0;
    logic [31:0] exp_rdout = 32'h0;

    always #5 clk = ~clk;

    spi_port_arbiter_if bus();
    spi_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Controller model: 4-deep tx fifo, 1-3 cycles per byte, non-ignored bytes return a response.
    always @(negedge clk) begin
        logic [8:0] head;
        logic [7:0] r;
        bus.spi_buffer_full  = txq.size() >= 4 || force_full;
        bus.spi_buffer_empty = txq.size() == 0;
        bus.spi_data_avail   = rxq.size() != 0;
        bus.spi_dout         = rxq.size() != 0 ? rxq[0] : 8'h00;
        #2;
        if (rst_n) begin
            if (bus.r_rdy) rdy_cnt++;
            if (bus.spi_rd && rxq.size() != 0) void'(rxq.pop_front());
            if (bus.spi_wr) begin
                if (bus.spi_buffer_full) stall_viol++;
                txq.push_back({bus.spi_ignore_response, bus.spi_din});
                pushed.push_back({bus.spi_ignore_response, bus.spi_din});
            end
            if (txq.size() != 0) begin
                if (shift_t == 0) begin
                    head = txq.pop_front();
                    if (!head[8]) begin
                        if (resp_fixed.size() != 0) r = resp_fixed.pop_front();
                        else r = 8'($urandom);
                        rxq.push_back(r);
                        resp.push_back(r);
                    end
                    shift_t = $urandom_range(2, 0);
                end else shift_t--;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.c_lock = 0; bus.c_wr = 0; bus.c_rd = 0; bus.c_ignore = 0; bus.c_din = 0;
        bus.r_wr = 0; bus.r_rd = 0; bus.r_addr = 0; bus.r_din = 0;
        force_full = 0;
        txq.delete(); rxq.delete(); pushed.delete(); resp.delete(); resp_fixed.delete();
        shift_t = 0;
        exp_rdout = 32'h0;
        tick();
        tick();
        check("rst_c_busy", bus.c_busy, 1);
        check("rst_r_rdy", bus.r_rdy, 0);
        check("rst_r_dout", bus.r_dout, 0);
        check("rst_spi_wr", bus.spi_wr, 0);
        check("rst_spi_rd", bus.spi_rd, 0);
        check("rst_spi_din", bus.spi_din, 0);
        check("rst_spi_ignore", bus.spi_ignore_response, 0);
        check("rst_c_data_avail", bus.c_data_avail, 0);
        rst_n = 1'b1;
    endtask

    task automatic cras_op(input bit wr, input logic [31:0] addr, input logic [31:0] din,
                           input bit stall, input bit contend);
        logic [8:0] exp_f[$];
        int rdy0 = rdy_cnt;
        bit done = 1'b0;
        bit stall_pending = stall;
        exp_f.push_back({1'b1, wr ? 8'h02 : 8'h03});
        for (int i = 2; i >= 0; i--) exp_f.push_back({1'b1, addr[8*i +: 8]});
        for (int i = 3; i >= 0; i--) exp_f.push_back(wr ? {1'b1, din[8*i +: 8]} : 9'h000);
        tick();
        bus.r_wr = wr; bus.r_rd = !wr; bus.r_addr = addr; bus.r_din = din;
        if (contend) bus.c_lock = 1'b1;
        for (int t = 0; t < 400 && !done; t++) begin
            tick();
            bus.c_wr = contend; bus.c_din = 8'h5A; bus.c_ignore = 1'b1;
            if (stall_pending && pushed.size() == 2) begin
                stall_pending = 1'b0;
                force_full = 1'b1;
                repeat (5) tick();
                check("stall_no_push", pushed.size(), 3);
                force_full = 1'b0;
            end
            if (bus.r_rdy) begin
                done = 1'b1;
                bus.r_wr = 0; bus.r_rd = 0; bus.c_wr = 0;
                if (!wr) begin
                    check("rd_resp_cnt", resp.size(), 4);
                    if (resp.size() >= 4) begin
                        exp_rdout = {resp[0], resp[1], resp[2], resp[3]};
                        repeat (4) void'(resp.pop_front());
                    end
                end
                check(wr ? "wr_rdout_held" : "rd_rdout", bus.r_dout, exp_rdout);
                check("frame_len", pushed.size(), 8);
                if (pushed.size() >= 8) begin
                    for (int i = 0; i < 8; i++) check("frame_byte", pushed[i], exp_f[i]);
                    repeat (8) void'(pushed.pop_front());
                end
                if (contend) check("core_blocked", bus.c_busy, 1);
            end
        end
        if (!done) check("rdy_timeout", 0, 1);
        bus.r_wr = 0; bus.r_rd = 0; bus.c_wr = 0;
        tick();
        tick();
        check("rdy_once", rdy_cnt - rdy0, 1);
    endtask

    task automatic core_txn(input int n);
        logic [8:0] exp_f[$];
        int sent = 0;
        int need = 0;
        int got = 0;
        int t = 0;
        tick();
        bus.c_lock = 1'b1;
        while (bus.c_busy && t < 300) begin tick(); t++; end
        check("core_grant", bus.c_busy, 0);
        t = 0;
        while ((sent < n || got < need) && t < 300) begin
            bus.c_wr = sent < n;
            bus.c_rd = bus.c_data_avail;
            if (bus.c_rd) begin
                got++;
                if (resp.size() != 0) check("core_dout", bus.c_dout, resp.pop_front());
                else check("core_spurious_avail", 1, 0);
            end
            if (sent < n) begin
                bus.c_din = 8'($urandom);
                bus.c_ignore = 1'($urandom_range(1, 0));
                exp_f.push_back({bus.c_ignore, bus.c_din});
                need += bus.c_ignore ? 0 : 1;
                sent++;
            end
            tick();
            t++;
        end
        bus.c_wr = 0; bus.c_rd = 0; bus.c_lock = 0;
        check("core_resp_cnt", got, need);
        t = 0;
        while (!bus.c_busy && t < 300) begin tick(); t++; end
        check("core_release", bus.c_busy, 1);
        check("core_push_cnt_min", pushed.size() >= n, 1);
        for (int i = 0; i < n && pushed.size() != 0; i++) check("core_byte", pushed.pop_front(), exp_f[i]);
    endtask

    initial begin
        int t;
        int rdy0;
        do_reset();
        // First tie after reset goes to CRAS in both builds; core then gets the port.
        cras_op(1, 32'h0012_3456, 32'hDEAD_BEEF, 0, 1);
        core_txn(2);
        resp_fixed = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        cras_op(0, 32'h0000_0010, 32'h0, 0, 0);
        check("rd_aabbccdd", bus.r_dout, 32'hAABB_CCDD);
        tick();
        bus.c_lock = 1'b1; bus.r_rd = 1'b1; bus.r_addr = 32'h0000_0080;
        tick();
`ifdef SPI_ARB_RR_EN
        check("tie2_core_first", bus.c_busy, 0);
        core_txn(2);
        cras_op(0, 32'h0000_0080, 32'h0, 0, 0);
`else
        check("tie2_cras_first", bus.c_busy, 1);
        cras_op(0, 32'h0000_0080, 32'h0, 0, 0);
        core_txn(2);
`endif
        cras_op(1, 32'h00AB_CDEF, 32'h1122_3344, 1, 0);
        check("stall_viol", stall_viol, 0);
        tick();
        bus.r_wr = 1'b1; bus.r_addr = 32'h0055_6677; bus.r_din = 32'h8899_AABB;
        t = 0;
        while (pushed.size() < 5 && t < 100) begin tick(); t++; end
        check("abort_reached_idx5", pushed.size(), 5);
        rdy0 = rdy_cnt;
        do_reset();
        tick();
        check("abort_no_rdy", rdy_cnt, rdy0);
        cras_op(1, 32'h0055_6677, 32'h8899_AABB, 0, 0);
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(3, 0))
                0: cras_op(1, $urandom, $urandom, 1'($urandom_range(1, 0)), 0);
                1: cras_op(0, $urandom, 32'h0, 1'($urandom_range(1, 0)), 0);
                2: core_txn($urandom_range(4, 1));
                default: begin
`ifdef SPI_ARB_RR_EN
                    core_txn(1);
`endif
                    cras_op(1'($urandom_range(1, 0)), $urandom, $urandom, 0, 1);
                    core_txn($urandom_range(4, 1));
                end
            endcase
        end
        check("no_push_while_full", stall_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule
